uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Sequencing controller between the UART receiver, the ALU and the UART transmitter. It collects three received bytes in order (operand A, operand B, opcode) and holds them on the ALU inputs. It then captures the ALU result and hands it to the transmitter with a one-cycle start pulse, and waits for transmission to finish before accepting a new command. An inactivity timeout discards a partially received command.

## Interface

Parameters:
- `DBIT`, 8: data width of UART bytes, ALU operands and result.
- `NB_OP`, 6: opcode width; `NB_OP` ≤ `DBIT`.
- `TIMEOUT`, 1000000: `clk` cycles of inactivity allowed inside a partial command; 32-bit; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `rx_done_tick`  in  1  one-cycle pulse: `rx_dout` holds a new byte.
- `rx_dout`  in  DBIT  received byte.
- `alu_result`  in  DBIT  combinational ALU output driven from `alu_a`/`alu_b`/`alu_op`.
- `tx_done_tick`  in  1  one-cycle pulse: transmitter finished the byte.
- `alu_a`  out  DBIT  operand A register.
- `alu_b`  out  DBIT  operand B register.
- `alu_op`  out  NB_OP  opcode register.
- `tx_din`  out  DBIT  byte to transmit (captured result).
- `tx_start`  out  1  one-cycle transmit request.
- `busy`  out  1  high from opcode capture until `tx_done_tick` is seen.
- `timeout_tick`  out  1  one-cycle pulse: partial command discarded.
- `overrun_tick`  out  1  one-cycle pulse: byte received while busy and dropped.

## Operation

- The FSM has six states:
  - WAIT_A: on `rx_done_tick`, `alu_a` ← `rx_dout`, clear the timer, go to WAIT_B.
  - WAIT_B: on `rx_done_tick`, `alu_b` ← `rx_dout`, clear the timer, go to WAIT_OP.
  - WAIT_OP: on `rx_done_tick`, `alu_op` ← `rx_dout[NB_OP-1:0]`, go to EXEC.
  - EXEC: exactly one cycle; `tx_din` ← `alu_result`; go to SEND.
  - SEND: exactly one cycle; `tx_start` = 1; go to WAIT_TX.
  - WAIT_TX: on `tx_done_tick`, go to WAIT_A.
- Timer:
  - Runs only in WAIT_B and WAIT_OP, incrementing every cycle and clearing on every accepted byte.
  - When it reaches `TIMEOUT`-1 with no `rx_done_tick`, it pulses `timeout_tick`, goes to WAIT_A and clears.
  - `alu_a`, `alu_b` and `alu_op` keep their last values on timeout.
- `rx_done_tick` and the timeout can occur in the same cycle. The byte wins: it is accepted, and there is no timeout.
- `rx_done_tick` in EXEC, SEND or WAIT_TX drops the byte and pulses `overrun_tick` the next cycle. Registers are unchanged.
- `tx_done_tick` outside WAIT_TX is ignored.
- `busy` = 1 in EXEC, SEND and WAIT_TX; it is registered and aligned with the state.
- Arithmetic: the timer is a 32-bit unsigned counter and never wraps, because the compare to `TIMEOUT`-1 resets it. No other arithmetic.

## Timing

- All outputs are registered. Reset values:
  - state WAIT_A
  - `alu_a`, `alu_b`, `tx_din` = 0
  - `alu_op` = 0
  - `tx_start`, `busy`, `timeout_tick`, `overrun_tick` = 0
  - timer = 0
- Reset is asynchronous. Asserting it mid-operation (including during SEND) forces every output to its reset value immediately. Operation resumes in WAIT_A on the first rising edge after release.
- Latency, with the opcode `rx_done_tick` sampled at edge N:
  - `alu_op` is valid after N and the state is EXEC.
  - `tx_din` is valid after N+1.
  - `tx_start` is high for exactly the cycle between edges N+2 and N+3.
  - `busy` rises after N and falls on the edge that samples `tx_done_tick`.
- The ALU must settle within one cycle, between edges N and N+1.
- Back-to-back: a byte arriving in the same cycle the FSM enters WAIT_A (the cycle after `tx_done_tick` is sampled) is accepted as operand A.
- `timeout_tick` and `overrun_tick` are each high for exactly one cycle per event.

## Test plan

- Reset, then bytes 0x05, 0x03, opcode 0x20 (ALU ADD) -> `alu_a`=0x05, `alu_b`=0x03, `alu_op`=0x20; `tx_din`=0x08; single `tx_start` pulse 2 cycles after the opcode tick; `busy` high until `tx_done_tick`.
- `TIMEOUT`=16, byte 0xAA then silence -> `timeout_tick` after 16 cycles, state WAIT_A. A following command 0x01, 0x02, 0x20 -> `tx_din`=0x03.
- `TIMEOUT`=16, second byte arrives exactly in the timeout cycle -> accepted as B, no `timeout_tick`.
- Byte 0x77 injected during WAIT_TX -> `overrun_tick` pulse; `alu_a`, `alu_b`, `alu_op` and `tx_din` unchanged; next command is processed normally.
- `reset` driven low during SEND -> `tx_start`, `busy` and the data registers are 0 immediately. After release, the command 0xFF, 0x01, 0x20 -> `tx_din`=0x00.
- Two commands back-to-back, with the first byte of the second arriving the cycle after `tx_done_tick` -> both results transmitted and no overrun.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// Sequencer between UART RX, a combinational ALU and UART TX: it collects operand A,
// operand B and an opcode, transmits the ALU result and drops partial commands on inactivity.
module uart_alu_ctrl #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned NB_OP   = 6,
   parameter logic [31:0] TIMEOUT = 32'd1000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_done_tick,
   input  logic [DBIT-1:0]  rx_dout,
   input  logic [DBIT-1:0]  alu_result,
   input  logic             tx_done_tick,
   output logic [DBIT-1:0]  alu_a,
   output logic [DBIT-1:0]  alu_b,
   output logic [NB_OP-1:0] alu_op,
   output logic [DBIT-1:0]  tx_din,
   output logic             tx_start,
   output logic             busy,
   output logic             timeout_tick,
   output logic             overrun_tick
);

   typedef enum logic [2:0] {
      S_WAIT_A,
      S_WAIT_B,
      S_WAIT_OP,
      S_EXEC,
      S_SEND,
      S_WAIT_TX
   } state_t;

   state_t            state_q;
   logic [31:0]       timer_q;
   logic [31:0]       timer_d;
   logic              timer_hit;
   logic [DBIT-1:0]   a_q;
   logic [DBIT-1:0]   b_q;
   logic [NB_OP-1:0]  op_q;
   logic [DBIT-1:0]   tx_din_q;
   logic              tx_start_q;
   logic              busy_q;
   logic              timeout_q;
   logic              overrun_q;

   assign timer_d   = timer_q + 32'd1;
   assign timer_hit = (timer_q == (TIMEOUT - 32'd1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_WAIT_A;
         timer_q    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         tx_din_q   <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
         unique case (state_q)
            S_WAIT_A: begin
               timer_q <= '0;
               if (rx_done_tick) begin
                  a_q     <= rx_dout;
                  state_q <= S_WAIT_B;
               end
            end
            // An arriving byte takes priority over an expiring timer.
            S_WAIT_B: begin
               if (rx_done_tick) begin
                  b_q     <= rx_dout;
                  timer_q <= '0;
                  state_q <= S_WAIT_OP;
               end else if (timer_hit) begin
                  timeout_q <= 1'b1;
                  timer_q   <= '0;
                  state_q   <= S_WAIT_A;
               end else begin
                  timer_q <= timer_d;
               end
            end
            S_WAIT_OP: begin
               if (rx_done_tick) begin
                  op_q    <= rx_dout[NB_OP-1:0];
                  timer_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_EXEC;
               end else if (timer_hit) begin
                  timeout_q <= 1'b1;
                  timer_q   <= '0;
                  state_q   <= S_WAIT_A;
               end else begin
                  timer_q <= timer_d;
               end
            end
            S_EXEC: begin
               tx_din_q  <= alu_result;
               overrun_q <= rx_done_tick;
               state_q   <= S_SEND;
            end
            // tx_start is registered, so the pulse lands in the first WAIT_TX cycle.
            S_SEND: begin
               tx_start_q <= 1'b1;
               overrun_q  <= rx_done_tick;
               state_q    <= S_WAIT_TX;
            end
            S_WAIT_TX: begin
               overrun_q <= rx_done_tick;
               if (tx_done_tick) begin
                  busy_q  <= 1'b0;
                  state_q <= S_WAIT_A;
               end
            end
            default: begin
               state_q <= S_WAIT_A;
            end
         endcase
      end
   end

   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_op       = op_q;
   assign tx_din       = tx_din_q;
   assign tx_start     = tx_start_q;
   assign busy         = busy_q;
   assign timeout_tick = timeout_q;
   assign overrun_tick = overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: directed scenarios followed by random traffic,
// with expected transmit, timeout and overrun events queued by a command-level model.
module tb_uart_alu_ctrl;

   localparam int unsigned TO = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_dout = '0;
   logic [7:0] alu_result;
   logic       tx_done_tick = 1'b0;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [5:0] alu_op;
   logic [7:0] tx_din;
   logic       tx_start;
   logic       busy;
   logic       timeout_tick;
   logic       overrun_tick;

   uart_alu_ctrl #(.DBIT(8), .NB_OP(6), .TIMEOUT(32'(TO))) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_dout      (rx_dout),
      .alu_result   (alu_result),
      .tx_done_tick (tx_done_tick),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .tx_din       (tx_din),
      .tx_start     (tx_start),
      .busy         (busy),
      .timeout_tick (timeout_tick),
      .overrun_tick (overrun_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
      case (op)
         6'h20:   alu_f = a + b;
         6'h22:   alu_f = a - b;
         6'h24:   alu_f = a & b;
         6'h25:   alu_f = a | b;
         6'h26:   alu_f = a ^ b;
         6'h27:   alu_f = ~(a | b);
         6'h02:   alu_f = a >> b[2:0];
         6'h03:   alu_f = $signed(a) >>> b[2:0];
         default: alu_f = 8'h00;
      endcase
   endfunction

   always_comb alu_result = alu_f(alu_a, alu_b, alu_op);

   typedef struct {
      int unsigned cyc;
      logic [7:0]  res;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [5:0]  op;
   } txexp_t;

   txexp_t      txq[$];
   int unsigned toq[$];
   int unsigned ovq[$];

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Command-level reference state
   logic [7:0]  m_bytes[$];
   logic [7:0]  m_a, m_b, m_res;
   logic [5:0]  m_op;
   bit          m_busy;
   int unsigned m_busy_start;
   int unsigned m_last_acc;

   logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      toq.delete();
      ovq.delete();
      m_bytes.delete();
      m_a = '0; m_b = '0; m_res = '0; m_op = '0;
      m_busy = 1'b0;
      m_busy_start = 0;
      m_last_acc = 0;
   endtask

   // Applies the spec rules to the inputs sampled at edge number cyc.
   task automatic model_edge(input bit rx, input logic [7:0] d, input bit txd);
      if (m_busy) begin
         if (rx) ovq.push_back(cyc);
         if (txd && cyc >= m_busy_start + 3) m_busy = 1'b0;
      end else if (rx) begin
         m_bytes.push_back(d);
         m_last_acc = cyc;
         if (m_bytes.size() == 1) m_a = d;
         else if (m_bytes.size() == 2) m_b = d;
         else begin
            m_op  = d[5:0];
            m_res = alu_f(m_a, m_b, m_op);
            txq.push_back('{cyc: cyc + 2, res: m_res, a: m_a, b: m_b, op: m_op});
            m_busy = 1'b1;
            m_busy_start = cyc;
            m_bytes.delete();
         end
      end else if (m_bytes.size() != 0 && cyc - m_last_acc == TO) begin
         toq.push_back(cyc);
         m_bytes.delete();
      end
   endtask

   task automatic cycle(input bit rx, input logic [7:0] d, input bit txd);
      rx_done_tick = rx;
      rx_dout      = d;
      tx_done_tick = txd;
      @(posedge clk);
      #1;
      model_edge(rx, d, txd);
      rx_done_tick = 1'b0;
      tx_done_tick = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      cycle(1'b1, d, 1'b0);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
   endtask

   task automatic txdone();
      cycle(1'b0, 8'h00, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_timeout_tick"}, 32'(timeout_tick), 32'd0);
      chk({tag, "_overrun_tick"}, 32'(overrun_tick), 32'd0);
      chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
      chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_tx_din"}, 32'(tx_din), 32'd0);
   endtask

   always @(negedge clk) begin : monitor
      txexp_t e;
      bit     exp_start, exp_to, exp_ov;
      if (reset) begin
         chk("busy", 32'(busy), 32'(m_busy));
         if (txq.size() != 0 && cyc + 1 == txq[0].cyc)
            chk("tx_din_early", 32'(tx_din), 32'(txq[0].res));
         exp_start = (txq.size() != 0 && txq[0].cyc == cyc);
         chk("tx_start", 32'(tx_start), 32'(exp_start));
         if (exp_start) begin
            e = txq.pop_front();
            chk("tx_din", 32'(tx_din), 32'(e.res));
            chk("alu_a", 32'(alu_a), 32'(e.a));
            chk("alu_b", 32'(alu_b), 32'(e.b));
            chk("alu_op", 32'(alu_op), 32'(e.op));
         end
         exp_to = (toq.size() != 0 && toq[0] == cyc);
         chk("timeout_tick", 32'(timeout_tick), 32'(exp_to));
         exp_ov = (ovq.size() != 0 && ovq[0] == cyc);
         chk("overrun_tick", 32'(overrun_tick), 32'(exp_ov));
         if (exp_to) void'(toq.pop_front());
         if (exp_ov) void'(ovq.pop_front());
         if (exp_to || exp_ov) begin
            chk("hold_alu_a", 32'(alu_a), 32'(m_a));
            chk("hold_alu_b", 32'(alu_b), 32'(m_b));
            chk("hold_alu_op", 32'(alu_op), 32'(m_op));
            chk("hold_tx_din", 32'(tx_din), 32'(m_res));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b1;

      // ADD 5 + 3
      send(8'h05); send(8'h03); send(8'h20);
      idle(3); txdone(); idle(2);

      // Partial command times out, then a normal command
      send(8'hAA); idle(TO + 4);
      send(8'h01); send(8'h02); send(8'h20);
      idle(3); txdone(); idle(1);

      // Operand B lands exactly on the timeout cycle
      send(8'h11); idle(TO - 1); send(8'h22); send(8'h25);
      idle(3); txdone(); idle(1);

      // Overrun during WAIT_TX, then a normal command
      send(8'h10); send(8'h20); send(8'h22);
      idle(3); send(8'h77); idle(1); txdone(); idle(1);
      send(8'h09); send(8'h04); send(8'h26);
      idle(3); txdone(); idle(1);

      // Reset asserted while in SEND
      send(8'h30); send(8'h31); send(8'h20);
      idle(1);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_zero("rst_send");
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      send(8'hFF); send(8'h01); send(8'h20);
      idle(3); txdone(); idle(1);

      // Back-to-back commands
      send(8'h40); send(8'h02); send(8'h22);
      idle(3); txdone();
      send(8'h06); send(8'h07); send(8'h24);
      idle(3); txdone(); idle(2);

      // Random traffic
      for (int unsigned it = 0; it < 1500; it++) begin
         int unsigned r;
         bit          rx, txd;
         logic [7:0]  d;
         r   = $urandom_range(0, 99);
         d   = 8'($urandom);
         rx  = 1'b0;
         txd = 1'b0;
         if (m_busy) begin
            rx  = (r < 8);
            txd = ($urandom_range(0, 3) == 0);
         end else if (r < 3) begin
            idle($urandom_range(TO - 2, TO + 2));
            continue;
         end else begin
            rx  = (r < 45);
            txd = (r >= 95);
            if (m_bytes.size() == 2 && $urandom_range(0, 3) != 0)
               d = {2'($urandom), ops[$urandom_range(0, 7)]};
         end
         cycle(rx, d, txd);
      end

      for (int i = 0; i < 8 && m_busy; i++)
         cycle(1'b0, 8'h00, (cyc + 1 >= m_busy_start + 3));
      idle(TO + 4);
      chk("queues_drained", 32'(txq.size() + toq.size() + ovq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
